// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// Holds the state encodings, ALU op codes and default register/op masks.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IN1  = 3'd1,
    S_IN2  = 3'd2,
    S_EVAL = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  // P0 (highest index) is read-only; CMP only updates flags.
  localparam logic [4:0] DEF_WP_MASK   = 5'b10000;
  localparam logic [7:0] DEF_NOWB_MASK = 8'b1000_0000;

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; all zeros when disabled.
module onehot_dec #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  for (genvar k = 0; k < N; k++) begin : g_bit
    assign onehot[k] = en && (idx == W'(k));
  end

endmodule

// File: rtl/alu_seq_fsm.sv
// Sequences one "op Ri Rj" instruction through register reads, ALU eval and
// writeback, rejecting out-of-range or write-protected destinations.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int                      NUM_REGS  = 5,
  parameter int                      SEL_W     = 3,
  parameter int                      OP_W      = 3,
  parameter logic [NUM_REGS-1:0]     WP_MASK   = 5'b10000,
  parameter logic [(1<<OP_W)-1:0]    NOWB_MASK = 8'b1000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [3:0]          opCode,
  input  logic [SEL_W-1:0]    Ri,
  input  logic [SEL_W-1:0]    Rj,
  output logic [NUM_REGS-1:0] reg_read,
  output logic [NUM_REGS-1:0] reg_write,
  output logic [OP_W-1:0]     ALU_opControl,
  output logic                ALU_alu_out_en,
  output logic                ALU_writeIN1,
  output logic                ALU_writeIN2,
  output logic                ALU_read,
  output logic                busy,
  output logic                done,
  output logic                err,
  output state_t              state_dbg
);

  // Handshake: an instruction is accepted on a rising edge where start=1 and
  // the FSM is in IDLE; done (with err on rejection) pulses one cycle before
  // the FSM returns to IDLE, and start is ignored in every other state.

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [SEL_W-1:0]  ri_q, rj_q;
  logic              wb_q;

  logic              accept;
  logic              idx_bad;
  logic              wb_need;
  logic              wp_hit;
  logic              rd_en, wr_en;
  logic [SEL_W-1:0]  rd_idx;
  logic              unused_bits;

  assign accept      = (state_q == S_IDLE) && start;
  assign idx_bad     = (32'(Ri) >= 32'(NUM_REGS)) || (32'(Rj) >= 32'(NUM_REGS));
  assign wb_need     = ~NOWB_MASK[opCode[OP_W-1:0]];
  assign unused_bits = &{1'b0, opCode};

  always_comb begin
    wp_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (Ri == SEL_W'(k)) wp_hit = WP_MASK[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ri_q    <= '0;
      rj_q    <= '0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= opCode[OP_W-1:0];
        ri_q <= Ri;
        rj_q <= Rj;
        wb_q <= wb_need;
      end
    end
  end

  always_comb begin
    state_d        = S_IDLE;
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    rd_idx         = ri_q;
    ALU_opControl  = '0;
    ALU_alu_out_en = 1'b0;
    ALU_writeIN1   = 1'b0;
    ALU_writeIN2   = 1'b0;
    ALU_read       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (idx_bad || (wb_need && wp_hit)) ? S_ERR : S_IN1;
      end
      S_IN1: begin
        busy         = 1'b1;
        rd_en        = 1'b1;
        ALU_writeIN1 = 1'b1;
        state_d      = S_IN2;
      end
      S_IN2: begin
        busy         = 1'b1;
        rd_en        = 1'b1;
        rd_idx       = rj_q;
        ALU_writeIN2 = 1'b1;
        state_d      = S_EVAL;
      end
      S_EVAL: begin
        busy           = 1'b1;
        ALU_alu_out_en = 1'b1;
        ALU_opControl  = op_q;
        state_d        = wb_q ? S_WB : S_DONE;
      end
      S_WB: begin
        busy     = 1'b1;
        wr_en    = 1'b1;
        ALU_read = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_ERR: begin
        busy = 1'b1;
        done = 1'b1;
        err  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

  onehot_dec #(.N(NUM_REGS), .W(SEL_W)) u_rd_dec (
    .idx    (rd_idx),
    .en     (rd_en),
    .onehot (reg_read)
  );

  onehot_dec #(.N(NUM_REGS), .W(SEL_W)) u_wr_dec (
    .idx    (ri_q),
    .en     (wr_en),
    .onehot (reg_write)
  );

endmodule
